// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the ARM core front end.
//   fetch_state_t    : instruction-fetch FSM states (IDLE/REQ/WAIT/DROP)
//   fetch_entry_t    : one buffered fetch result, {pc, instr}
//   XLEN, INSTR_BYTES, FETCH_BUF_DEPTH, DEFAULT_RESET_PC
//   word_align()     : clears the byte-offset bits of an address
package core_pkg;

  localparam int XLEN            = 32;
  localparam int INSTR_BYTES     = 4;
  localparam int FETCH_BUF_DEPTH = 2;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_instr_queue.sv
// instr_queue: 2-entry FIFO of {pc, instr} entries between fetch and decode.
// The head always lives in entry0_r, so the head outputs come straight
// from registers; a pop shifts entry1 down.
//   clk, reset   : clock, synchronous active-high reset
//   flush        : synchronous flush, overrides push and pop
//   push, push_data : write an entry (ignored when full unless popping)
//   pop          : consume the head (ignored when empty)
//   head         : current head entry
//   full, empty, count : occupancy status
import core_pkg::*;

module instr_queue (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t entry0_r;
  fetch_entry_t entry1_r;
  logic         valid0_r;
  logic         valid1_r;
  logic         pop_en_s;
  logic         push_en_s;

  // Qualify push/pop against occupancy; a full queue accepts a push only
  // when the head leaves in the same cycle.
  always_comb begin
    pop_en_s  = pop & valid0_r;
    push_en_s = push & (~valid1_r | pop_en_s);
  end

  // Storage update: flush, shift on pop, fill the lowest free slot on push.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      entry0_r <= '0;
      entry1_r <= '0;
      valid0_r <= 1'b0;
      valid1_r <= 1'b0;
    end else begin
      case ({push_en_s, pop_en_s})
        2'b01: begin
          entry0_r <= entry1_r;
          valid0_r <= valid1_r;
          valid1_r <= 1'b0;
        end
        2'b10: begin
          if (!valid0_r) begin
            entry0_r <= push_data;
            valid0_r <= 1'b1;
          end else begin
            entry1_r <= push_data;
            valid1_r <= 1'b1;
          end
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry lands behind whatever remains.
          if (valid1_r) begin
            entry0_r <= entry1_r;
            entry1_r <= push_data;
          end else begin
            entry0_r <= push_data;
          end
        end
        default: begin
          entry0_r <= entry0_r;
        end
      endcase
    end
  end

  assign head  = entry0_r;
  assign full  = valid1_r;
  assign empty = ~valid0_r;
  assign count = {1'b0, valid0_r} + {1'b0, valid1_r};

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Holds the architectural PC,
// issues one word fetch at a time over a valid/ready channel, buffers the
// responses with their PC for the decoder, and handles redirects by
// flushing the buffer and dropping any wrong-path fetch still in flight.
//   clk, reset                     : clock, synchronous active-high reset
//   redirect_valid, redirect_pc    : PC redirect from next-PC select
//   imem_req_valid/ready, imem_addr: fetch request channel
//   imem_rsp_valid, imem_rdata     : fetch response
//   instr_valid/ready, instr, instr_pc : decoder-side queue head
//   pc                             : next fetch PC
import core_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc
);

  fetch_state_t    state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] req_pc_r;
  logic            req_valid_r;

  logic            handshake_s;
  logic            push_s;
  logic            pop_s;
  logic            room_s;
  logic [2:0]      count_next_s;
  logic [1:0]      count_s;
  logic            full_s;
  logic            empty_s;
  fetch_entry_t    push_data_s;
  fetch_entry_t    head_s;

  // Queue control and post-update occupancy. Redirect suppresses both push
  // and pop so a flushed cycle never counts as a consume.
  always_comb begin
    handshake_s  = req_valid_r & imem_req_ready;
    pop_s        = ~empty_s & instr_ready & ~redirect_valid;
    push_s       = imem_rsp_valid & (state_r == WAIT) & ~redirect_valid
                   & (~full_s | pop_s);
    push_data_s  = '{pc: req_pc_r, instr: imem_rdata};
    count_next_s = {1'b0, count_s} + {2'b00, push_s} - {2'b00, pop_s};
    // Room is judged on the occupancy after this cycle's push/pop, so a
    // pop from a full queue lets the next request go out right away.
    room_s       = (count_next_s < 3'(BUF_DEPTH));
  end

  // Fetch FSM with the PC register and the registered request valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      pc_r        <= word_align(RESET_PC);
      req_pc_r    <= 32'h0000_0000;
      req_valid_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r <= word_align(redirect_pc);
      case (state_r)
        IDLE: begin
          state_r     <= REQ;
          req_valid_r <= 1'b1;
        end
        REQ: begin
          // A request accepted this cycle is wrong-path; its response must be eaten.
          if (handshake_s) begin
            state_r     <= DROP;
            req_valid_r <= 1'b0;
          end else begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
          end
        end
        WAIT, DROP: begin
          if (imem_rsp_valid) begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
          end else begin
            state_r     <= DROP;
            req_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        IDLE: begin
          if (room_s) begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
          end else begin
            state_r     <= IDLE;
            req_valid_r <= 1'b0;
          end
        end
        REQ: begin
          if (handshake_s) begin
            req_pc_r    <= pc_r;
            pc_r        <= pc_r + 32'(INSTR_BYTES);
            state_r     <= WAIT;
            req_valid_r <= 1'b0;
          end else begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state_r     <= room_s ? REQ : IDLE;
            req_valid_r <= room_s;
          end else begin
            state_r     <= WAIT;
            req_valid_r <= 1'b0;
          end
        end
        DROP: begin
          if (imem_rsp_valid) begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
          end else begin
            state_r     <= DROP;
            req_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  instr_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = pc_r;
  assign pc             = pc_r;
  assign instr_valid    = ~empty_s;
  assign instr          = head_s.instr;
  assign instr_pc       = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. Two instances share all inputs: u_dut uses the
// default reset PC and is checked every cycle against a transaction-level
// model; u_wrap starts at 0xFFFF_FFFC to exercise PC wrap-around.
module tb_fetch_unit;

  localparam logic [31:0] KEY     = 32'hA5A5_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_ready = 1'b0;

  logic        imem_req_valid, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc, pc;
  logic        w_req_valid, w_instr_valid;
  logic [31:0] w_addr, w_instr, w_instr_pc, w_pc;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .pc(pc)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready), .instr(w_instr),
    .instr_pc(w_instr_pc), .pc(w_pc)
  );

  int total = 0;
  int passed = 0;

  // Reference model: architectural PC, expected queue contents, and the
  // single in-flight fetch (with a wrong-path flag).
  logic [31:0] mpc;
  logic [63:0] mq[$];
  logic        m_out, m_wrong, exp_req;
  logic [31:0] m_addr;
  logic [31:0] mem_addr;
  logic [31:0] got_pcs[$];
  logic [31:0] w_addrs[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    mpc = 32'h0;
    mq.delete();
    m_out = 1'b0;
    m_wrong = 1'b0;
    exp_req = 1'b0;
    mem_addr = 32'h0;
    got_pcs.delete();
    w_addrs.delete();
  endtask

  task automatic check_outputs();
    chk("pc", pc, mpc);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_addr, mpc);
    chk("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("instr_pc", instr_pc, mq[0][63:32]);
      chk("instr", instr, mq[0][31:0]);
    end
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic cycle(input logic rdr, input logic [31:0] rpc, input logic mrdy,
                       input logic drdy, input logic arsp);
    logic hs, pop, rsp;
    check_outputs();
    redirect_valid = rdr;
    redirect_pc    = rpc;
    imem_req_ready = mrdy;
    instr_ready    = drdy;
    rsp            = m_out & arsp;
    imem_rsp_valid = rsp;
    imem_rdata     = rsp ? (mem_addr ^ KEY) : $urandom();
    hs  = imem_req_valid & mrdy;
    pop = instr_valid & drdy;
    if (pop && !rdr) got_pcs.push_back(instr_pc);
    if (w_req_valid && mrdy) w_addrs.push_back(w_addr);
    if (hs) mem_addr = imem_addr;
    if (rdr) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
      if (hs) begin
        m_out = 1'b1;
        m_wrong = 1'b1;
      end else if (m_out && rsp) begin
        m_out = 1'b0;
        m_wrong = 1'b0;
      end else if (m_out) begin
        m_wrong = 1'b1;
      end
    end else begin
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (m_out && rsp) begin
        if (!m_wrong) mq.push_back({m_addr, m_addr ^ KEY});
        m_out = 1'b0;
        m_wrong = 1'b0;
      end
      if (hs) begin
        m_out = 1'b1;
        m_wrong = 1'b0;
        m_addr = mpc;
        mpc = mpc + 32'd4;
      end
    end
    // Fetch whenever nothing is in flight and the buffer has room.
    exp_req = !m_out && (mq.size() < 2);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_instr_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_wrap_pc", w_pc, WRAP_PC);
      chk("rst_wrap_addr", w_addr, WRAP_PC);
      chk("rst_wrap_head", w_instr ^ w_instr_pc ^ 32'(w_instr_valid), 32'h0);
    end
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int guard;
    int n_before;
    @(posedge clk);
    #1;

    // Reset held 3 cycles; the model then expects IDLE, then a request at 0x0.
    do_reset(3);

    // Streaming: one instruction per 2 cycles, in order.
    repeat (14) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("stream_count", 32'(got_pcs.size()), 32'd6);
    for (int i = 0; i < 3 && i < got_pcs.size(); i++)
      chk("stream_pc", got_pcs[i], 32'(i * 4));

    // Backpressure: queue fills with 0x0 and 0x4, fetching stops.
    do_reset(2);
    repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("bp_head", instr_pc, 32'h0);
    chk("bp_no_req", 32'(imem_req_valid), 32'h0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("bp_req_after_pop", 32'(imem_req_valid), 32'h1);
    chk("bp_req_addr", imem_addr, 32'h8);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    // Redirect to 0x103 while waiting for 0x8.
    cycle(1'b1, 32'h103, 1'b1, 1'b0, 1'b0);
    chk("rd_flushed", 32'(instr_valid), 32'h0);
    chk("rd_pc", pc, 32'h100);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("rd_drop", 32'(instr_valid), 32'h0);
    got_pcs.delete();
    repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("rd_first_count", 32'(got_pcs.size() > 0), 32'h1);
    if (got_pcs.size() > 0) chk("rd_first_pc", got_pcs[0], 32'h100);

    // Redirect coinciding with a response and a pop.
    do_reset(2);
    for (guard = 0; guard < 20 && !(m_out && mq.size() == 1); guard++)
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("same_setup", 32'(m_out && mq.size() == 1), 32'h1);
    n_before = got_pcs.size();
    cycle(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    chk("same_no_pop", 32'(got_pcs.size()), 32'(n_before));
    chk("same_no_instr", 32'(instr_valid), 32'h0);
    chk("same_pc", pc, 32'h200);
    chk("same_req", 32'(imem_req_valid), 32'h1);
    chk("same_addr", imem_addr, 32'h200);

    // Randomized traffic against the model.
    repeat (600)
      cycle($urandom_range(0, 15) == 0, $urandom(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);

    // Wrap-around from 0xFFFF_FFFC.
    do_reset(3);
    repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    chk("wrap_count", 32'(w_addrs.size() >= 2), 32'h1);
    if (w_addrs.size() >= 2) begin
      chk("wrap_first", w_addrs[0], WRAP_PC);
      chk("wrap_second", w_addrs[1], 32'h0);
    end

    // Reset mid-WAIT, then a late response while idle/requesting.
    for (guard = 0; guard < 10 && !m_out; guard++)
      cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("late_setup", 32'(m_out), 32'h1);
    do_reset(2);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("late_no_push", 32'(instr_valid), 32'h0);
      chk("late_no_push_wrap", 32'(w_instr_valid), 32'h0);
    end
    chk("late_wrap_pc", w_pc, WRAP_PC);
    imem_rsp_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
